// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a byte FIFO on the LPC clock domain.
//   Bytes are pushed through a valid/ready handshake, buffered in a circular
//   FIFO, and serialised LSB-first as start / data / [parity] / stop(1|2).
//   Parity and stop-bit settings are latched when each byte is popped.
//
// Build option: define UART_TX_PARITY_EN to include the PARITY state and the
//   parity_mode decode; without it every frame is sent without parity and
//   parity_mode is ignored.
//
// Parameters: DIVISOR (clocks per bit, 2..65535), DATA_BITS (5..8),
//             FIFO_AW (FIFO address width, depth 2**FIFO_AW).
// Ports:
//   lpc_clk      in   clock, rising edge
//   lpc_rst_n    in   asynchronous active-low reset
//   tx_data      in   [7:0] byte to send (bits above DATA_BITS-1 ignored)
//   tx_valid     in   producer has a byte
//   tx_ready     out  FIFO not full
//   parity_mode  in   [1:0] 00 none, 01 odd, 10 even, 11 none
//   stop2        in   1 = two stop bits
//   txd          out  serial line, idle high
//   busy         out  frame in progress or FIFO non-empty
//   fifo_level   out  [FIFO_AW:0] entries stored
module uart_tx_fifo #(
  parameter int unsigned DIVISOR   = 286,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic               lpc_clk,
  input  logic               lpc_rst_n,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [1:0]         parity_mode,
  input  logic               stop2,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int unsigned          CNT_W     = $clog2(DIVISOR);
  localparam int unsigned          DEPTH     = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0]     BAUD_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [2:0]           BIT_LAST  = 3'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  // FIFO storage and pointers
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Transmit datapath
  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic             baud_tick;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             stop_cnt;
  logic             stop2_q;
`ifdef UART_TX_PARITY_EN
  logic             par_en_q;
  logic             par_bit_q;
`endif

  // Full when the wrap bits differ and the address bits match.
  assign full       = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign tx_ready   = !full;
  assign push       = tx_valid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign fifo_level = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[FIFO_AW-1:0]];
  assign busy       = (state != IDLE) || !empty;
  assign baud_tick  = (baud_cnt == BAUD_LAST);

  always_ff @(posedge lpc_clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst_n) begin
    if (!lpc_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst_n) begin
    if (!lpc_rst_n) begin
      state    <= IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      stop_cnt <= 1'b0;
      stop2_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      if (state != IDLE) begin
        baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
          if (!empty) begin
            shreg   <= head;
            stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= parity_mode[0] ^ parity_mode[1];
            // Even parity is the XOR of the data bits; odd inverts it.
            par_bit_q <= (^(head & DATA_MASK)) ^ (parity_mode == 2'b01);
`endif
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud_tick) begin
            state   <= DATA;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state <= PARITY;
                txd   <= par_bit_q;
              end else begin
                state    <= STOP;
                txd      <= 1'b1;
                stop_cnt <= 1'b0;
              end
`else
              state    <= STOP;
              txd      <= 1'b1;
              stop_cnt <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            state    <= STOP;
            txd      <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
`endif
        STOP: begin
          txd <= 1'b1;
          if (baud_tick) begin
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       sel;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       txd_a, txd_b;
  logic       busy_a, busy_b;
  logic [2:0] level_a, level_b;

  int checks = 0;
  int errors = 0;

  logic cap_en = 1'b0;
  logic cap_txd[$];
  logic cap_busy[$];
  logic exp_txd[$];
  logic exp_busy[$];

  always #5 clk = ~clk;

  assign valid_a = tx_valid && !sel;
  assign valid_b = tx_valid && sel;

  uart_tx_fifo #(.DIVISOR(DIV), .DATA_BITS(8), .FIFO_AW(2)) dut (
    .lpc_clk(clk), .lpc_rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_a),
    .tx_ready(ready_a), .parity_mode(parity_mode), .stop2(stop2),
    .txd(txd_a), .busy(busy_a), .fifo_level(level_a)
  );

  uart_tx_fifo #(.DIVISOR(DIV), .DATA_BITS(5), .FIFO_AW(2)) dut5 (
    .lpc_clk(clk), .lpc_rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_b),
    .tx_ready(ready_b), .parity_mode(parity_mode), .stop2(stop2),
    .txd(txd_b), .busy(busy_b), .fifo_level(level_b)
  );

  always @(negedge clk) begin
    if (cap_en) begin
      cap_txd.push_back(sel ? txd_b : txd_a);
      cap_busy.push_back(sel ? busy_b : busy_a);
    end
  end

  // Reference model: a frame is a list of bits, each held for DIV clocks.
  task automatic model_frame(input logic [7:0] d, input logic [1:0] mode,
                             input logic s2, input int db);
    logic bits[$];
    int   ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PAR_BUILT && (mode == 2'b01 || mode == 2'b10))
      bits.push_back((mode == 2'b10) ? (ones % 2 == 1) : (ones % 2 == 0));
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      repeat (DIV) begin
        exp_txd.push_back(bits[i]);
        exp_busy.push_back(1'b1);
      end
    end
  endtask

  task automatic model_gap();
    exp_txd.push_back(1'b1);
    exp_busy.push_back(1'b1);
  endtask

  task automatic model_tail();
    repeat (4) begin
      exp_txd.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic begin_capture();
    cap_txd.delete();
    cap_busy.delete();
    exp_txd.delete();
    exp_busy.delete();
    cap_en = 1'b1;
  endtask

  task automatic end_capture();
    repeat (exp_txd.size() + 8) @(negedge clk);
    cap_en = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  function automatic int find_start();
    foreach (cap_txd[i]) if (cap_txd[i] === 1'b0) return i;
    return -1;
  endfunction

  // Index of first disagreement between capture and model (-1 none, -2 no frame).
  function automatic int first_mismatch(input bit which, output logic act_v,
                                        output logic exp_v);
    int st;
    act_v = 1'bz;
    exp_v = 1'bz;
    st = find_start();
    if (st < 0) return -2;
    for (int i = 0; i < exp_txd.size(); i++) begin
      exp_v = which ? exp_busy[i] : exp_txd[i];
      if (st + i >= cap_txd.size()) return i;
      act_v = which ? cap_busy[st + i] : cap_txd[st + i];
      if (act_v !== exp_v) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    checks++; if (txd_a !== 1'b1)  begin errors++; $display("FAIL reset_txd got %b exp 1", txd_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level_a); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (txd_b !== 1'b1 || busy_b !== 1'b0 || level_b !== 3'd0)
      begin errors++; $display("FAIL reset_dut5 txd=%b busy=%b level=%0d exp 1 0 0", txd_b, busy_b, level_b); end
    checks++; if (txd_a !== 1'b1 || busy_a !== 1'b0)
      begin errors++; $display("FAIL after_reset txd=%b busy=%b exp 1 0", txd_a, busy_a); end
  endtask

  task automatic test_a5();
    int mm; logic av, ev;
    sel = 1'b0; parity_mode = 2'b00; stop2 = 1'b0;
    begin_capture();
    push_byte(8'hA5);
    model_frame(8'hA5, 2'b00, 1'b0, 8);
    model_tail();
    end_capture();
    mm = first_mismatch(1'b0, av, ev);
    checks++; if (mm != -1) begin errors++; $display("FAIL a5_txd sample %0d got %b exp %b", mm, av, ev); end
    mm = first_mismatch(1'b1, av, ev);
    checks++; if (mm != -1) begin errors++; $display("FAIL a5_busy sample %0d got %b exp %b", mm, av, ev); end
  endtask

  task automatic test_parity();
    logic [1:0] modes [3] = '{2'b10, 2'b01, 2'b11};
    int mm, st; logic av, ev, ep, eb;
    sel = 1'b0; stop2 = 1'b0;
    for (int m = 0; m < 3; m++) begin
      parity_mode = modes[m];
      begin_capture();
      push_byte(8'h07);
      model_frame(8'h07, modes[m], 1'b0, 8);
      model_tail();
      end_capture();
      mm = first_mismatch(1'b0, av, ev);
      checks++; if (mm != -1) begin errors++; $display("FAIL parity%0d_txd sample %0d got %b exp %b", modes[m], mm, av, ev); end
      // Bit 9 of 0x07: 1 for even, 0 for odd, stop bit otherwise.
      // busy at clock 40 tells a 44-clock frame from a 40-clock one.
      ep = (PAR_BUILT && modes[m] == 2'b01) ? 1'b0 : 1'b1;
      eb = PAR_BUILT && modes[m] != 2'b11;
      st = find_start();
      checks++;
      if (st < 0 || st + 40 >= cap_txd.size()) begin
        errors++; $display("FAIL parity%0d_bit no frame seen got none exp %b", modes[m], ep);
      end else if (cap_txd[st + 36] !== ep || cap_busy[st + 40] !== eb) begin
        errors++;
        $display("FAIL parity%0d_bit got bit=%b busy40=%b exp %b %b", modes[m], cap_txd[st + 36], cap_busy[st + 40], ep, eb);
      end
    end
  endtask

  task automatic test_db5();
    int mm; logic av, ev;
    sel = 1'b1; parity_mode = 2'b00; stop2 = 1'b1;
    begin_capture();
    push_byte(8'hFF);
    model_frame(8'hFF, 2'b00, 1'b1, 5);
    model_tail();
    end_capture();
    mm = first_mismatch(1'b0, av, ev);
    checks++; if (mm != -1) begin errors++; $display("FAIL db5_txd sample %0d got %b exp %b", mm, av, ev); end
    mm = first_mismatch(1'b1, av, ev);
    checks++; if (mm != -1) begin errors++; $display("FAIL db5_busy sample %0d got %b exp %b", mm, av, ev); end
    sel = 1'b0;
  endtask

  task automatic test_fifo_fill();
    int lv [5] = '{1, 1, 2, 3, 4};
    logic [7:0] b [5];
    int mm; logic av, ev;
    sel = 1'b0; parity_mode = 2'b00; stop2 = 1'b0;
    begin_capture();
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom);
      tx_data = b[i];
      tx_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (level_a !== 3'(lv[i])) begin
        errors++; $display("FAIL fill_level push%0d got %0d exp %0d", i, level_a, lv[i]);
      end
    end
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", ready_a); end
    tx_data = 8'hEE;
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    checks++; if (level_a !== 3'd4) begin errors++; $display("FAIL full_hold_level got %0d exp 4", level_a); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) model_gap();
      model_frame(b[i], 2'b00, 1'b0, 8);
    end
    model_tail();
    end_capture();
    mm = first_mismatch(1'b0, av, ev);
    checks++; if (mm != -1) begin errors++; $display("FAIL fill_txd sample %0d got %b exp %b", mm, av, ev); end
    mm = first_mismatch(1'b1, av, ev);
    checks++; if (mm != -1) begin errors++; $display("FAIL fill_busy sample %0d got %b exp %b", mm, av, ev); end
  endtask

  task automatic test_config_latch();
    logic [7:0] b0, b1;
    int mm; logic av, ev;
    sel = 1'b0; parity_mode = 2'b10; stop2 = 1'b1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    begin_capture();
    push_byte(b0);
    @(negedge clk);
    parity_mode = 2'b01; stop2 = 1'b0;
    push_byte(b1);
    model_frame(b0, 2'b10, 1'b1, 8);
    model_gap();
    model_frame(b1, 2'b01, 1'b0, 8);
    model_tail();
    end_capture();
    mm = first_mismatch(1'b0, av, ev);
    checks++; if (mm != -1) begin errors++; $display("FAIL cfg_latch_txd sample %0d got %b exp %b", mm, av, ev); end
    mm = first_mismatch(1'b1, av, ev);
    checks++; if (mm != -1) begin errors++; $display("FAIL cfg_latch_busy sample %0d got %b exp %b", mm, av, ev); end
  endtask

  task automatic test_random();
    int n, mm; logic av, ev; logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      sel         = 1'($urandom_range(0, 1));
      parity_mode = 2'($urandom_range(0, 3));
      stop2       = 1'($urandom_range(0, 1));
      n           = int'($urandom_range(1, 3));
      begin_capture();
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        push_byte(d);
        if (i > 0) model_gap();
        model_frame(d, parity_mode, stop2, sel ? 5 : 8);
      end
      model_tail();
      end_capture();
      mm = first_mismatch(1'b0, av, ev);
      checks++; if (mm != -1) begin errors++; $display("FAIL rand%0d_txd sample %0d got %b exp %b", k, mm, av, ev); end
      mm = first_mismatch(1'b1, av, ev);
      checks++; if (mm != -1) begin errors++; $display("FAIL rand%0d_busy sample %0d got %b exp %b", k, mm, av, ev); end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    sel = 1'b0; parity_mode = 2'b00; stop2 = 1'b0;
    push_byte(8'h00);
    push_byte(8'h00);
    repeat (10) @(negedge clk);
    checks++; if (txd_a !== 1'b0 || busy_a !== 1'b1)
      begin errors++; $display("FAIL midframe_pre txd=%b busy=%b exp 0 1", txd_a, busy_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (txd_a !== 1'b1)   begin errors++; $display("FAIL rst_mid_txd got %b exp 1", txd_a); end
    checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL rst_mid_level got %0d exp 0", level_a); end
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy_a); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_more_frames got %0d active samples exp 0", bad); end
  endtask

  initial begin
    rst_n = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    sel = 1'b0;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_a5();
    test_parity();
    test_db5();
    test_fifo_fill();
    test_config_latch();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
